// File: rtl/barcode_pkg.sv
// Shared types and defaults for the barcode LED sequencer and its symbol FIFO.
package barcode_pkg;

  localparam int DEFAULT_WIDTH_W = 12;
  localparam int DEFAULT_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic                       level;
    logic                       last;
    logic [DEFAULT_WIDTH_W-1:0] width;
  } sym_t;

endpackage

// File: rtl/barcode_sym_fifo.sv
// Symbol FIFO with first-word fall-through head, flush and occupancy count.
// A push is judged against the pre-pop count, so a full FIFO refuses it.
module barcode_sym_fifo
  import barcode_pkg::*;
#(
  parameter int DATA_W = DEFAULT_WIDTH_W + 2,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    do_push  = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/barcode_pwm_seq.sv
// Bar/space symbol sequencer driving the barcode LED pad: per-symbol timing via
// a prescaler, optional IR carrier gating, and a per-frame drive-code latch.
module barcode_pwm_seq
  import barcode_pkg::*;
#(
  parameter int WIDTH_W = DEFAULT_WIDTH_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   prescale,
  input  logic               carrier_en,
  input  logic [DIV_W-1:0]   carrier_div,
  input  logic [3:0]         drv_strength,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic               sym_level,
  input  logic [WIDTH_W-1:0] sym_width,
  input  logic               sym_last,
  output logic               barcode_pwm,
  output logic [3:0]         cbit_barcode,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic               level;
    logic               last;
    logic [WIDTH_W-1:0] width;
  } sym_w_t;

  sym_w_t             head, push_sym;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full, pop, tick;

  state_e             state_q, state_d;
  logic               level_q, level_d, last_q, last_d;
  logic [WIDTH_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0]   presc_q, presc_d, carr_q, carr_d;
  logic               phase_q, phase_d, pwm_q, pwm_d;
  logic [3:0]         cbit_q, cbit_d;
  logic               done_q, done_d, underrun_q, underrun_d;
  logic               from_idle_q, from_idle_d;
  logic               run_q;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  // run_q keeps ready low while reset is held, independent of en.
  assign sym_ready  = en && run_q && !fifo_full;
  assign push_sym   = '{level: sym_level, last: sym_last, width: sym_width};

  barcode_sym_fifo #(
    .DATA_W($bits(sym_w_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(!en),
    .push_i (sym_valid && sym_ready),
    .data_i (push_sym),
    .pop_i  (pop),
    .head_o (head),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    carr_d      = carr_q;
    phase_d     = phase_q;
    cbit_d      = cbit_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    pop         = 1'b0;
    tick        = (presc_q == prescale);
    from_idle_d = (state_q == IDLE);

    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        presc_d = '0;
        // Drive code and carrier restart only on the first LOAD of a frame.
        if (from_idle_q) begin
          cbit_d  = drv_strength;
          carr_d  = '0;
          phase_d = 1'b1;
        end
        if (fifo_empty) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
        end else begin
          pop         = 1'b1;
          level_d     = head.level;
          last_d      = head.last;
          remaining_d = head.width;
          if (head.width != '0) begin
            state_d = RUN;
          end else if (head.last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (carr_q == carrier_div) begin
          carr_d  = '0;
          phase_d = !phase_q;
        end else begin
          carr_d = carr_q + DIV_W'(1);
        end
        if (tick) begin
          presc_d     = '0;
          remaining_d = remaining_q - WIDTH_W'(1);
          if (remaining_q == WIDTH_W'(1)) begin
            if (last_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (fifo_empty) begin
              state_d    = IDLE;
              underrun_d = 1'b1;
            end else begin
              pop         = 1'b1;
              level_d     = head.level;
              last_d      = head.last;
              remaining_d = head.width;
              if (head.width == '0) begin
                if (head.last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = LOAD;
                end
              end
            end
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d    = IDLE;
      pop        = 1'b0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      cbit_d     = cbit_q;
    end

    // LOAD holds the previous level so a skipped symbol only stretches it.
    if (state_d == RUN)       pwm_d = level_d & (carrier_en ? phase_d : 1'b1);
    else if (state_d == LOAD) pwm_d = pwm_q;
    else                      pwm_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= 1'b0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      presc_q     <= '0;
      carr_q      <= '0;
      phase_q     <= 1'b0;
      pwm_q       <= 1'b0;
      cbit_q      <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      from_idle_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      carr_q      <= carr_d;
      phase_q     <= phase_d;
      pwm_q       <= pwm_d;
      cbit_q      <= cbit_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      from_idle_q <= from_idle_d;
      run_q       <= 1'b1;
    end
  end

  assign barcode_pwm  = pwm_q;
  assign cbit_barcode = cbit_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign underrun     = underrun_q;

endmodule
